// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared widths, entry record and register reset table
package reg_writeback_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  // One pending write-back: retire-only entries carry reg_write = 0
  typedef struct packed {
    logic                 reg_write;
    logic [REG_IDX_W-1:0] write_reg;
    logic [DATA_W-1:0]    write_data;
  } wb_entry_t;

  localparam logic [DATA_W-1:0] REG_RESET_TABLE [NUM_REGS] = '{
    32'h3, 32'h4, 32'h1, 32'h2, 32'h3, 32'h0, 32'h5, 32'ha,
    32'h2, 32'hd, 32'ha, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
  };

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// rtl/reg_writeback_wb_fifo.sv - pending write-back FIFO with visible slots for bypass
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        entries [DEPTH],
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Overflowing pushes and underflowing pops are dropped here so callers need not gate them
  always_comb begin
    full    = (count == (PTR_W+1)'(DEPTH));
    push_ok = push && !full;
    pop_ok  = pop && (count != '0);
    entries = mem;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - buffered register-file write-back with read bypass
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 WB_VALID,
  output logic                 WB_READY,
  input  logic                 RegWrite,
  input  logic [REG_IDX_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]    WriteData,
  input  logic                 COMMIT_EN,
  input  logic [REG_IDX_W-1:0] ReadReg1,
  input  logic [REG_IDX_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]    A,
  output logic [DATA_W-1:0]    B,
  output logic [PTR_W:0]       PENDING
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  wb_entry_t         entries [DEPTH];
  wb_entry_t         din;
  wb_entry_t         head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  slot;
  logic              full;
  logic              push;
  logic              commit;

  // Ready depends only on occupancy, never on the commit port
  always_comb begin
    WB_READY = !full;
    push     = WB_VALID && WB_READY;
    commit   = COMMIT_EN && (PENDING != '0);
    din      = '{reg_write: RegWrite, write_reg: WriteReg, write_data: WriteData};
    head     = entries[rd_ptr];
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .reset   (RESET),
    .push    (push),
    .pop     (COMMIT_EN),
    .din     (din),
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (PENDING),
    .full    (full)
  );

  // Reset loads the fixed table; otherwise the oldest entry retires when the write port is free
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= REG_RESET_TABLE[i];
      end
    end else if (commit && head.reg_write) begin
      regs[head.write_reg] <= head.write_data;
    end
  end

  // Walk live slots oldest to newest so the newest matching write wins the bypass
  always_comb begin
    A    = regs[ReadReg1];
    B    = regs[ReadReg2];
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < PENDING) && entries[slot].reg_write) begin
        if (entries[slot].write_reg == ReadReg1) A = entries[slot].write_data;
        if (entries[slot].write_reg == ReadReg2) B = entries[slot].write_data;
      end
    end
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write buffer entries (power of two, 2..16).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 WB_VALID  input  1  write-back request present this cycle.
REQ-005 WB_READY  output  1  block can accept a request this cycle.
REQ-006 RegWrite  input  1  request writes the register file (0 = retire without writing).
REQ-007 WriteReg  input  5  destination register index.
REQ-008 WriteData  input  32  result to write (ALUOut).
REQ-009 COMMIT_EN  input  1  register-file write port available this cycle.
REQ-010 ReadReg1, ReadReg2  input  5 each  read indices.
REQ-011 A, B  output  32 each  read data, including bypassed pending writes.
REQ-012 PENDING  output  log2(DEPTH)+1  number of buffered entries.

Function
REQ-013 The block SHALL accept a request on a rising edge where WB_VALID=1 and WB_READY=1, pushing {RegWrite, WriteReg, WriteData} into a FIFO.
REQ-014 WB_READY SHALL be 1 exactly when PENDING < DEPTH; it is combinational from the count and does not depend on COMMIT_EN.
REQ-015 On each rising edge where COMMIT_EN=1 and PENDING>0, the oldest entry SHALL be popped, and REGS[WriteReg] SHALL be written with WriteData only if its RegWrite=1.
REQ-016 A simultaneous push and pop SHALL leave PENDING unchanged. A push into an empty FIFO SHALL NOT commit on the same edge; the minimum accept-to-commit latency is 1 cycle.
REQ-017 A and B SHALL be combinational functions of the read indices. Each returns WriteData of the newest FIFO entry with RegWrite=1 and a matching index, or otherwise REGS[index].
REQ-018 Register 0 SHALL be an ordinary writable register (not hardwired to zero).
REQ-019 Entries SHALL commit strictly in acceptance order. After a full drain, REGS SHALL equal the result of applying all accepted writes in order.
REQ-020 FIFO read and write pointers SHALL wrap modulo DEPTH. A push SHALL be ignored when full, and a pop SHALL be ignored when empty.
REQ-021 Requests SHALL NOT be lost or duplicated while WB_VALID is held high with WB_READY=0.

Reset
REQ-022 On a rising edge with RESET=1, PENDING SHALL become 0 and all buffered entries SHALL be discarded without committing.
REQ-023 On reset, REGS SHALL load the reset table: R0=3, R1=4, R2=1, R3=2, R4=3, R5=0, R6=5, R7=0xa, R8=2, R9=0xd, R10=0xa, R11..R31=0.
REQ-024 RESET SHALL take priority over a push and a pop on the same edge. After reset, WB_READY=1, and A/B reflect the reset table.

Structure
REQ-025 The shared package SHALL hold REG_RESET_TABLE (32x32 constant), the register-index width (5), the data width (32), and the FIFO entry record type.
REQ-026 The FIFO with its pointers and count SHALL be a sub-module wb_fifo. Bypass search, the REGS array and commit logic SHALL stay in reg_writeback.

Verification
REQ-027 Scenario 1: reset, then push {1, R2, 7} with COMMIT_EN=0, then ReadReg1=2.
  - Required: A=7 in the next cycle, PENDING=1.
  - Then set COMMIT_EN=1. Required: PENDING=0 after 1 edge, and A still 7 (from REGS).
REQ-028 Scenario 2: with COMMIT_EN=0, push 4 entries.
  - Required: WB_READY=0 and PENDING=4; a 5th request held with WB_VALID=1 is not accepted.
  - Then pulse COMMIT_EN for 1 cycle. Required: the 5th request is accepted on the following edge, and PENDING=4.
REQ-029 Scenario 3: push {1, R9, 0x11}, then {1, R9, 0x22}, with ReadReg2=9.
  - Required: B=0x22 while both are pending; after a full drain, B=0x22.
REQ-030 Scenario 4: push {0, R6, 0xFF} and drain.
  - Required: PENDING returns to 0, and ReadReg1=6 gives A=5.
REQ-031 Scenario 5: buffer 3 writes to R9 (COMMIT_EN=0), then assert RESET for 1 cycle.
  - Required: PENDING=0, WB_READY=1, and ReadReg1=9 gives A=0xd.
REQ-032 Scenario 6: random push/commit traffic for 10k cycles.
  - Required: REGS matches a reference model after the final drain, and PENDING never exceeds DEPTH.
